// File: rtl/pwm_capture_if.sv
// pwm_capture_if: PWM input line and measurement results of one capture channel.
// The master modport is the capture block, the slave modport is its user.
interface pwm_capture_if #(
    parameter int CNT_W = 16
);
    logic             pwm_in;
    logic [CNT_W-1:0] period_cnt;
    logic [CNT_W-1:0] high_cnt;
    logic             meas_valid;
    logic             stuck;
    logic             stuck_level;

    modport master (
        input  pwm_in,
        output period_cnt,
        output high_cnt,
        output meas_valid,
        output stuck,
        output stuck_level
    );

    modport slave (
        output pwm_in,
        input  period_cnt,
        input  high_cnt,
        input  meas_valid,
        input  stuck,
        input  stuck_level
    );
endinterface

// File: rtl/pwm_capture.sv
// pwm_capture: measures period and high time of an asynchronous PWM line in clk cycles.
// Results latch once per period with a one-cycle strobe; a line without edges is flagged stuck.
module pwm_capture #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1000
) (
    input  logic          clk,
    input  logic          rst,
    pwm_capture_if.master bus
);

    if (TIMEOUT < 2 || longint'(TIMEOUT) > (longint'(1) << CNT_W) - 1) begin : g_bad_timeout
        $error("pwm_capture: TIMEOUT out of range");
    end

    typedef enum logic {
        S_WAIT,
        S_MEASURE
    } state_t;

    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    logic sync_meta;
    logic sync_level;
    logic prev_level;
    logic rise;
    logic rise_q;

    state_t state;
    state_t state_d;

    logic [CNT_W-1:0] per_run;
    logic [CNT_W-1:0] per_d;
    logic [CNT_W-1:0] hi_run;
    logic [CNT_W-1:0] hi_d;
    logic [CNT_W-1:0] period_q;
    logic [CNT_W-1:0] period_d;
    logic [CNT_W-1:0] high_q;
    logic [CNT_W-1:0] high_d;
    logic             valid_q;
    logic             valid_d;
    logic             stuck_q;
    logic             stuck_d;
    logic             lvl_q;
    logic             lvl_d;

    assign rise = sync_level & ~prev_level;

    // rise is registered once more; prev_level is the level aligned with rise_q
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_meta  <= 1'b0;
            sync_level <= 1'b0;
            prev_level <= 1'b0;
            rise_q     <= 1'b0;
        end else begin
            sync_meta  <= bus.pwm_in;
            sync_level <= sync_meta;
            prev_level <= sync_level;
            rise_q     <= rise;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_WAIT;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d  = state;
        per_d    = per_run;
        hi_d     = hi_run;
        period_d = period_q;
        high_d   = high_q;
        valid_d  = 1'b0;
        stuck_d  = stuck_q;
        lvl_d    = lvl_q;
        if (rise_q) begin
            state_d = S_MEASURE;
            per_d   = ONE;
            hi_d    = ONE;
            stuck_d = 1'b0;
            if (state == S_MEASURE) begin
                valid_d  = 1'b1;
                period_d = per_run;
                high_d   = hi_run;
            end
        end else if (!stuck_q) begin
            // reaching TIMEOUT on this cycle: give up lock, keep last results
            if (per_run == TO_LAST) begin
                state_d = S_WAIT;
                per_d   = '0;
                hi_d    = '0;
                stuck_d = 1'b1;
                lvl_d   = prev_level;
            end else begin
                per_d = per_run + ONE;
                unique case (state)
                    S_MEASURE: hi_d = hi_run + CNT_W'(prev_level);
                    default:   hi_d = hi_run;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            per_run  <= '0;
            hi_run   <= '0;
            period_q <= '0;
            high_q   <= '0;
            valid_q  <= 1'b0;
            stuck_q  <= 1'b0;
            lvl_q    <= 1'b0;
        end else begin
            per_run  <= per_d;
            hi_run   <= hi_d;
            period_q <= period_d;
            high_q   <= high_d;
            valid_q  <= valid_d;
            stuck_q  <= stuck_d;
            lvl_q    <= lvl_d;
        end
    end

    assign bus.period_cnt  = period_q;
    assign bus.high_cnt    = high_q;
    assign bus.meas_valid  = valid_q;
    assign bus.stuck       = stuck_q;
    assign bus.stuck_level = lvl_q;

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: scenario tasks plus random segments for pwm_capture.
// An event-level reference model predicts strobes, results and stuck flags.
module tb_pwm_capture;

    localparam int CW = 16;
    localparam int TO = 100;

    logic clk = 1'b0;
    logic rst = 1'b1;

    pwm_capture_if #(.CNT_W(CW)) bus ();

    pwm_capture #(
        .CNT_W  (CW),
        .TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int at;
        int p;
        int h;
    } ev_t;

    int  total = 0;
    int  bad   = 0;
    int  cyc   = 8;
    bit  dv[0:65535];
    ev_t pq[$];
    bit  locked  = 1'b0;
    bit  e_valid = 1'b0;
    bit  e_stuck = 1'b0;
    bit  e_lvl   = 1'b0;
    int  e_per   = 0;
    int  e_hi    = 0;
    int  deadline = 0;
    int  lastm   = 0;
    int  hi_acc  = 0;

    // A rise sampled at edge m is acted on at edge m+3; result spans rise to rise.
    task automatic model_step(input bit v, input bit r);
        ev_t ev;
        cyc++;
        e_valid = 1'b0;
        if (r) begin
            dv[cyc]  = 1'b0;
            locked   = 1'b0;
            e_stuck  = 1'b0;
            e_lvl    = 1'b0;
            e_per    = 0;
            e_hi     = 0;
            pq.delete();
            deadline = cyc + TO;
            lastm    = cyc;
            hi_acc   = 0;
            return;
        end
        dv[cyc] = v;
        if (v && !dv[cyc-1]) begin
            pq.push_back('{at: cyc + 3, p: cyc - lastm, h: hi_acc});
            lastm  = cyc;
            hi_acc = 1;
        end else begin
            hi_acc += int'(v);
        end
        if (pq.size() != 0 && pq[0].at == cyc) begin
            ev = pq.pop_front();
            if (locked) begin
                e_valid = 1'b1;
                e_per   = ev.p;
                e_hi    = ev.h;
            end
            locked   = 1'b1;
            e_stuck  = 1'b0;
            deadline = cyc + TO - 1;
        end else if (!e_stuck && cyc == deadline) begin
            e_stuck = 1'b1;
            e_lvl   = dv[cyc-3];
            locked  = 1'b0;
        end
    endtask

    task automatic tick(input bit v, input bit r);
        @(negedge clk);
        bus.pwm_in = v;
        rst        = r;
        @(posedge clk);
        model_step(v, r);
        #1;
    endtask

    function automatic bit wave(input int t, input int p, input int h);
        return (t % p) < h;
    endfunction

    task automatic test_reset();
        for (int i = 0; i < 3; i++) tick(1'($urandom_range(0, 1)), 1'b1);
        total++;
        if (bus.meas_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_valid: got %0b want 0", bus.meas_valid);
        end
        total++;
        if (bus.stuck !== 1'b0 || bus.stuck_level !== 1'b0) begin
            bad++;
            $display("FAIL reset_stuck: got %0b/%0b want 0/0", bus.stuck, bus.stuck_level);
        end
        total++;
        if (bus.period_cnt !== 16'd0 || bus.high_cnt !== 16'd0) begin
            bad++;
            $display("FAIL reset_cnt: got %0d/%0d want 0/0", bus.period_cnt, bus.high_cnt);
        end
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, 1'b0);
            total++;
            if (bus.meas_valid !== e_valid || bus.stuck !== e_stuck || bus.stuck_level !== e_lvl ||
                bus.period_cnt !== CW'(e_per) || bus.high_cnt !== CW'(e_hi)) begin
                bad++;
                $display("FAIL reset_idle cyc=%0d: got v%0b s%0b l%0b %0d/%0d want v%0b s%0b l%0b %0d/%0d",
                         cyc, bus.meas_valid, bus.stuck, bus.stuck_level, bus.period_cnt, bus.high_cnt,
                         e_valid, e_stuck, e_lvl, e_per, e_hi);
            end
        end
    endtask

    task automatic test_steady();
        int ns   = 0;
        int last = -1;
        tick(1'b0, 1'b1);
        for (int i = 0; i < int'($urandom_range(1, 5)); i++) tick(1'b0, 1'b0);
        for (int t = 0; t < 6 * 16; t++) begin
            tick(wave(t, 16, 5), 1'b0);
            total++;
            if (bus.meas_valid !== e_valid || bus.stuck !== e_stuck || bus.stuck_level !== e_lvl ||
                bus.period_cnt !== CW'(e_per) || bus.high_cnt !== CW'(e_hi)) begin
                bad++;
                $display("FAIL steady cyc=%0d: got v%0b s%0b l%0b %0d/%0d want v%0b s%0b l%0b %0d/%0d",
                         cyc, bus.meas_valid, bus.stuck, bus.stuck_level, bus.period_cnt, bus.high_cnt,
                         e_valid, e_stuck, e_lvl, e_per, e_hi);
            end
            if (bus.meas_valid === 1'b1) begin
                ns++;
                total++;
                if (bus.period_cnt !== 16'd16 || bus.high_cnt !== 16'd5) begin
                    bad++;
                    $display("FAIL steady_val: got %0d/%0d want 16/5", bus.period_cnt, bus.high_cnt);
                end
                if (last >= 0) begin
                    total++;
                    if (cyc - last !== 16) begin
                        bad++;
                        $display("FAIL steady_gap: got %0d want 16", cyc - last);
                    end
                end
                last = cyc;
            end
        end
        total++;
        if (ns !== 5) begin
            bad++;
            $display("FAIL steady_count: got %0d want 5", ns);
        end
    endtask

    task automatic test_switch();
        int sp[$];
        int sh[$];
        int xp[5] = '{10, 10, 10, 10, 40};
        int xh[5] = '{1, 1, 1, 1, 39};
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);
        for (int t = 0; t < 4 * 10 + 2 * 40; t++) begin
            if (t < 40) tick(wave(t, 10, 1), 1'b0);
            else tick(wave(t - 40, 40, 39), 1'b0);
            total++;
            if (bus.meas_valid !== e_valid || bus.stuck !== e_stuck || bus.stuck_level !== e_lvl ||
                bus.period_cnt !== CW'(e_per) || bus.high_cnt !== CW'(e_hi)) begin
                bad++;
                $display("FAIL switch cyc=%0d: got v%0b s%0b l%0b %0d/%0d want v%0b s%0b l%0b %0d/%0d",
                         cyc, bus.meas_valid, bus.stuck, bus.stuck_level, bus.period_cnt, bus.high_cnt,
                         e_valid, e_stuck, e_lvl, e_per, e_hi);
            end
            if (bus.meas_valid === 1'b1) begin
                sp.push_back(int'(bus.period_cnt));
                sh.push_back(int'(bus.high_cnt));
            end
        end
        total++;
        if (sp.size() !== 5) begin
            bad++;
            $display("FAIL switch_count: got %0d want 5", sp.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                total++;
                if (sp[i] !== xp[i] || sh[i] !== xh[i]) begin
                    bad++;
                    $display("FAIL switch_val[%0d]: got %0d/%0d want %0d/%0d", i, sp[i], sh[i], xp[i], xh[i]);
                end
            end
        end
    endtask

    task automatic test_stuck_low();
        int clear_at = -1;
        int first_v  = -1;
        tick(1'b0, 1'b1);
        for (int k = 1; k <= 150; k++) begin
            tick(1'b0, 1'b0);
            total++;
            if (bus.meas_valid !== e_valid || bus.stuck !== e_stuck || bus.stuck_level !== e_lvl ||
                bus.period_cnt !== CW'(e_per) || bus.high_cnt !== CW'(e_hi)) begin
                bad++;
                $display("FAIL stuck_low cyc=%0d: got v%0b s%0b l%0b %0d/%0d want v%0b s%0b l%0b %0d/%0d",
                         cyc, bus.meas_valid, bus.stuck, bus.stuck_level, bus.period_cnt, bus.high_cnt,
                         e_valid, e_stuck, e_lvl, e_per, e_hi);
            end
            total++;
            if (bus.stuck !== 1'(k >= TO) || bus.stuck_level !== 1'b0) begin
                bad++;
                $display("FAIL stuck_low_time k=%0d: got s%0b l%0b want s%0b l0", k, bus.stuck,
                         bus.stuck_level, k >= TO);
            end
        end
        for (int t = 0; t < 3 * 20; t++) begin
            tick(wave(t, 20, 5), 1'b0);
            total++;
            if (bus.meas_valid !== e_valid || bus.stuck !== e_stuck || bus.stuck_level !== e_lvl ||
                bus.period_cnt !== CW'(e_per) || bus.high_cnt !== CW'(e_hi)) begin
                bad++;
                $display("FAIL stuck_low_train cyc=%0d: got v%0b s%0b %0d/%0d want v%0b s%0b %0d/%0d",
                         cyc, bus.meas_valid, bus.stuck, bus.period_cnt, bus.high_cnt,
                         e_valid, e_stuck, e_per, e_hi);
            end
            if (clear_at < 0 && bus.stuck === 1'b0) clear_at = t;
            if (first_v < 0 && bus.meas_valid === 1'b1) first_v = t;
        end
        total++;
        if (clear_at !== 3) begin
            bad++;
            $display("FAIL stuck_low_clear: got t=%0d want t=3", clear_at);
        end
        total++;
        if (first_v - clear_at !== 20) begin
            bad++;
            $display("FAIL stuck_low_first_valid: got gap %0d want 20", first_v - clear_at);
        end
    endtask

    task automatic test_stuck_high();
        int lp = -1;
        int lh = -1;
        tick(1'b0, 1'b1);
        for (int t = 0; t < 4 * 16 + 200; t++) begin
            tick((t < 64) ? wave(t, 16, 8) : 1'b1, 1'b0);
            total++;
            if (bus.meas_valid !== e_valid || bus.stuck !== e_stuck || bus.stuck_level !== e_lvl ||
                bus.period_cnt !== CW'(e_per) || bus.high_cnt !== CW'(e_hi)) begin
                bad++;
                $display("FAIL stuck_high cyc=%0d: got v%0b s%0b l%0b %0d/%0d want v%0b s%0b l%0b %0d/%0d",
                         cyc, bus.meas_valid, bus.stuck, bus.stuck_level, bus.period_cnt, bus.high_cnt,
                         e_valid, e_stuck, e_lvl, e_per, e_hi);
            end
            if (bus.meas_valid === 1'b1) begin
                lp = int'(bus.period_cnt);
                lh = int'(bus.high_cnt);
            end
        end
        total++;
        if (lp !== 16 || lh !== 8) begin
            bad++;
            $display("FAIL stuck_high_last: got %0d/%0d want 16/8", lp, lh);
        end
        total++;
        if (bus.stuck !== 1'b1 || bus.stuck_level !== 1'b1 ||
            bus.period_cnt !== 16'd16 || bus.high_cnt !== 16'd8) begin
            bad++;
            $display("FAIL stuck_high_end: got s%0b l%0b %0d/%0d want s1 l1 16/8",
                     bus.stuck, bus.stuck_level, bus.period_cnt, bus.high_cnt);
        end
    endtask

    task automatic test_mid_reset();
        int post = 0;
        tick(1'b0, 1'b1);
        for (int t = 0; t < 70; t++) begin
            tick(wave(t, 16, 5), 1'(t == 39));
            total++;
            if (bus.meas_valid !== e_valid || bus.stuck !== e_stuck || bus.stuck_level !== e_lvl ||
                bus.period_cnt !== CW'(e_per) || bus.high_cnt !== CW'(e_hi)) begin
                bad++;
                $display("FAIL mid_reset cyc=%0d: got v%0b s%0b %0d/%0d want v%0b s%0b %0d/%0d",
                         cyc, bus.meas_valid, bus.stuck, bus.period_cnt, bus.high_cnt,
                         e_valid, e_stuck, e_per, e_hi);
            end
            if (t == 39) begin
                total++;
                if (bus.meas_valid !== 1'b0 || bus.stuck !== 1'b0 ||
                    bus.period_cnt !== 16'd0 || bus.high_cnt !== 16'd0) begin
                    bad++;
                    $display("FAIL mid_reset_clear: got v%0b s%0b %0d/%0d want v0 s0 0/0",
                             bus.meas_valid, bus.stuck, bus.period_cnt, bus.high_cnt);
                end
            end
            if (t > 39 && bus.meas_valid === 1'b1) begin
                post++;
                total++;
                if (t !== 67 || bus.period_cnt !== 16'd16 || bus.high_cnt !== 16'd5) begin
                    bad++;
                    $display("FAIL mid_reset_strobe: got t=%0d %0d/%0d want t=67 16/5",
                             t, bus.period_cnt, bus.high_cnt);
                end
            end
        end
        total++;
        if (post !== 1) begin
            bad++;
            $display("FAIL mid_reset_count: got %0d want 1", post);
        end
    endtask

    task automatic test_period2();
        int ns   = 0;
        int last = -1;
        tick(1'b0, 1'b1);
        for (int t = 0; t < 42; t++) begin
            tick(wave(t, 2, 1), 1'b0);
            total++;
            if (bus.meas_valid !== e_valid || bus.stuck !== e_stuck || bus.stuck_level !== e_lvl ||
                bus.period_cnt !== CW'(e_per) || bus.high_cnt !== CW'(e_hi)) begin
                bad++;
                $display("FAIL period2 cyc=%0d: got v%0b %0d/%0d want v%0b %0d/%0d",
                         cyc, bus.meas_valid, bus.period_cnt, bus.high_cnt, e_valid, e_per, e_hi);
            end
            if (bus.meas_valid === 1'b1) begin
                ns++;
                total++;
                if (bus.period_cnt !== 16'd2 || bus.high_cnt !== 16'd1 ||
                    (last >= 0 && cyc - last !== 2)) begin
                    bad++;
                    $display("FAIL period2_val: got %0d/%0d gap %0d want 2/1 gap 2",
                             bus.period_cnt, bus.high_cnt, cyc - last);
                end
                last = cyc;
            end
        end
        total++;
        if (ns !== 19) begin
            bad++;
            $display("FAIL period2_count: got %0d want 19", ns);
        end
    endtask

    task automatic test_boundary();
        bit seen_stuck = 1'b0;
        tick(1'b0, 1'b1);
        for (int t = 0; t < 3 * 99 + 3 * 100; t++) begin
            if (t < 297) tick(wave(t, 99, 1), 1'b0);
            else tick(wave(t - 297, 100, 1), 1'b0);
            total++;
            if (bus.meas_valid !== e_valid || bus.stuck !== e_stuck || bus.stuck_level !== e_lvl ||
                bus.period_cnt !== CW'(e_per) || bus.high_cnt !== CW'(e_hi)) begin
                bad++;
                $display("FAIL boundary cyc=%0d: got v%0b s%0b %0d/%0d want v%0b s%0b %0d/%0d",
                         cyc, bus.meas_valid, bus.stuck, bus.period_cnt, bus.high_cnt,
                         e_valid, e_stuck, e_per, e_hi);
            end
            if (t < 297) begin
                total++;
                if (bus.stuck !== 1'b0 ||
                    (bus.meas_valid === 1'b1 && (bus.period_cnt !== 16'd99 || bus.high_cnt !== 16'd1))) begin
                    bad++;
                    $display("FAIL boundary_99: got s%0b v%0b %0d/%0d want s0 99/1",
                             bus.stuck, bus.meas_valid, bus.period_cnt, bus.high_cnt);
                end
            end else if (t > 300) begin
                total++;
                if (bus.meas_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL boundary_100_valid: got %0b want 0", bus.meas_valid);
                end
                if (bus.stuck === 1'b1) seen_stuck = 1'b1;
            end
        end
        total++;
        if (seen_stuck !== 1'b1) begin
            bad++;
            $display("FAIL boundary_100_stuck: got %0b want 1", seen_stuck);
        end
    endtask

    task automatic test_random();
        int kind;
        int p;
        int h;
        int n;
        bit lv;
        for (int s = 0; s < 30; s++) begin
            if ($urandom_range(0, 9) == 0) tick(1'($urandom_range(0, 1)), 1'b1);
            kind = int'($urandom_range(0, 3));
            p    = int'($urandom_range(2, 70));
            h    = int'($urandom_range(1, p - 1));
            lv   = 1'($urandom_range(0, 1));
            n    = (kind < 2) ? p * int'($urandom_range(1, 4)) : int'($urandom_range(1, 150));
            for (int t = 0; t < n; t++) begin
                unique case (kind)
                    0, 1:    tick(wave(t, p, h), 1'b0);
                    2:       tick(lv, 1'b0);
                    default: tick(1'($urandom_range(0, 1)), 1'b0);
                endcase
                total++;
                if (bus.meas_valid !== e_valid || bus.stuck !== e_stuck || bus.stuck_level !== e_lvl ||
                    bus.period_cnt !== CW'(e_per) || bus.high_cnt !== CW'(e_hi)) begin
                    bad++;
                    $display("FAIL random seg=%0d cyc=%0d: got v%0b s%0b l%0b %0d/%0d want v%0b s%0b l%0b %0d/%0d",
                             s, cyc, bus.meas_valid, bus.stuck, bus.stuck_level, bus.period_cnt,
                             bus.high_cnt, e_valid, e_stuck, e_lvl, e_per, e_hi);
                end
            end
        end
    endtask

    initial begin
        bus.pwm_in = 1'b0;
        rst        = 1'b1;
        test_reset();
        test_steady();
        test_switch();
        test_stuck_low();
        test_stuck_high();
        test_mid_reset();
        test_period2();
        test_boundary();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
- Measures an incoming single-bit PWM waveform and reports the period and the high time, both in clk cycles.
- It is the receive-side counterpart of the team's RGB PWM generator. It is used for loopback self-test of LED drive channels and to read duty-encoded sensor outputs in the health monitor.
- One instance per monitored line. Results are latched once per PWM period, and a one-cycle valid strobe flags each new result.

Parameters:
- CNT_W, 16, width of the period and high-time counters and of their outputs.
- TIMEOUT, 1000, number of cycles with no rising edge before the line is declared stuck. Legal range is 2 to 2^CNT_W-1, checked at elaboration.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- pwm_in  in  1  asynchronous PWM input.
- period_cnt  out  CNT_W  cycles between the last two rising edges.
- high_cnt  out  CNT_W  cycles the line was high within that period.
- meas_valid  out  1  one-cycle strobe when period_cnt and high_cnt update.
- stuck  out  1  no rising edge seen for TIMEOUT cycles.
- stuck_level  out  1  line level captured when stuck was set.

Behaviour:
- Synchronizer and edge detect:
  - pwm_in passes through a 2-flop synchronizer, then a third flop for edge detection.
  - rise = sync_level & ~prev_level.
  - All three flops reset to 0.
- Reset:
  - Sets period_cnt=0, high_cnt=0, meas_valid=0, stuck=0, stuck_level=0, the internal run counters to 0, and the state to WAIT.
  - Reset mid-period discards the partial measurement. No valid strobe is issued for it.
- State WAIT (after reset or after a timeout):
  - The input is not yet phase-locked.
  - On rise: go to MEASURE, set per_run=1, set hi_run=1, and clear stuck.
  - No meas_valid is issued on this edge.
  - per_run still counts while in WAIT so that timeout works.
- State MEASURE, per cycle without rise:
  - per_run += 1.
  - hi_run += sync_level.
- State MEASURE, cycle with rise:
  - Register period_cnt<=per_run and high_cnt<=hi_run.
  - Register meas_valid<=1 for exactly one cycle.
  - Reload per_run=1 and hi_run=1.
  - The result is therefore P and H for a waveform with period P and high time H, with 1 <= H <= P-1.
- Latency: a pwm_in rising edge meeting setup at clk edge k causes meas_valid to be high in the cycle following clk edge k+3.
- Timeout:
  - When per_run reaches TIMEOUT without a rise (any state): set stuck=1 and stuck_level<=sync_level.
  - Go to WAIT, reset per_run=0, and hold per_run at 0 while stuck=1.
  - period_cnt and high_cnt keep their last values. No meas_valid is issued.
  - stuck stays 1 until the next rise.
  - A constant-high input reports stuck=1 with stuck_level=1. A constant-low input reports stuck=1 with stuck_level=0.
- Simultaneous events: if rise and timeout coincide in the same cycle, rise wins. Counters stay below TIMEOUT, so they can never wrap.
- A high pulse of one synchronized cycle is measured as high_cnt=1. Pulses narrower than one clk period may be missed; this is accepted.
- meas_valid never asserts on two consecutive cycles. The minimum spacing between strobes is 2 cycles (period of 2).

Test Plan:
- Reset, then a steady PWM with period 16 and high 5 for 6 periods: the first edge gives no strobe. Each later edge gives meas_valid with period_cnt=16 and high_cnt=5, spaced exactly 16 cycles apart.
- Period 10, high 1, then a switch on an edge to period 40, high 39: the strobe at the switch reports 10/1. The next strobe reports 40/39.
- TIMEOUT=100 with pwm_in held low from reset: stuck=1 and stuck_level=0 exactly 100 cycles after WAIT per_run starts. Outputs stay 0 and no strobe occurs. A later pulse train clears stuck on its first rise, and the first valid appears one period later.
- pwm_in held high for 200 cycles after a 16/8 train (TIMEOUT=100): the last valid reports 16/8, then stuck=1 with stuck_level=1. Outputs remain 16/8.
- Assert rst for 1 cycle midway through a 16/5 period: all outputs return to 0 in the next cycle. The next edge gives no strobe, and the edge after it gives 16/5.
- Period 2, high 1, a one-clk pulse every other cycle: meas_valid every 2 cycles with period_cnt=2 and high_cnt=1.
